// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg: declarations shared by the serial pattern transmitter (seq_gen)
// and the sequence detector on the receiving end of the link.
//   state_e      - transmitter FSM state encoding (2 bits)
//   SEQ_PAT_W    - default pattern length
//   SEQ_PATTERN  - default pattern, transmitted MSB first
//   idx_width()  - minimum index width for a count of n items (at least 1)
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    localparam int unsigned          SEQ_PAT_W   = 6;
    localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 6'b101010;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_gen_shift.sv
// ---------------------------------------------------------------------------
// seq_gen_shift: combinational pattern indexer for seq_gen.
// Given the index of the bit currently on the wire and whether that bit is
// being accepted, produces the index and value of the bit to present next.
// The index wraps from 0 back to PAT_W-1 so repetitions chain seamlessly;
// whether a wrap actually starts a new repetition is decided by the caller.
// Ports:
//   bit_idx    in   IDX_W  index of the bit currently presented
//   advance    in   1      current bit accepted this cycle
//   last_c     out  1      current bit is the final bit of the pattern
//   next_idx_c out  IDX_W  index to present after this cycle
//   next_bit_c out  1      PATTERN[next_idx_c]
// ---------------------------------------------------------------------------
module seq_gen_shift
    import seq_pkg::*;
#(
    parameter int unsigned          PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0]     PATTERN = SEQ_PATTERN,
    parameter int unsigned          IDX_W   = idx_width(PAT_W)
) (
    input  logic [IDX_W-1:0] bit_idx,
    input  logic             advance,
    output logic             last_c,
    output logic [IDX_W-1:0] next_idx_c,
    output logic             next_bit_c
);

    assign last_c = (bit_idx == '0);

    // Step MSB -> LSB, wrapping to the MSB after bit 0.
    always_comb begin
        next_idx_c = bit_idx;
        if (advance) begin
            if (last_c) begin
                next_idx_c = IDX_W'(PAT_W - 1);
            end else begin
                next_idx_c = bit_idx - IDX_W'(1);
            end
        end
        next_bit_c = PATTERN[next_idx_c];
    end

endmodule

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen: serial pattern transmitter. Sends PATTERN (MSB first) `reps`
// times over a 1-bit valid/ready stream, then pulses done for one cycle.
// Optional build macro: SEQ_GEN_GAP_EN inserts GAP_LEN idle cycles
// between consecutive repetitions (never after the final one).
// Ports:
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      burst request, sampled only in IDLE
//   reps     in   REP_W  repetition count, captured with start
//   x        out  1      serial data bit
//   x_valid  out  1      x carries a valid bit
//   x_ready  in   1      sink accepts x when x_valid && x_ready
//   busy     out  1      burst in progress (acceptance to final beat)
//   done     out  1      one-cycle pulse after the final beat
// ---------------------------------------------------------------------------
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
    parameter int unsigned      REP_W   = 4,
    parameter int unsigned      GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    output logic             x,
    output logic             x_valid,
    input  logic             x_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = idx_width(PAT_W);

    state_e             state_q,   state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic               x_q,       x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic               accept_c;
    logic               last_c;
    logic [IDX_W-1:0]   next_idx_c;
    logic               next_bit_c;

`ifdef SEQ_GEN_GAP_EN
    localparam int unsigned GAP_W = idx_width(GAP_LEN);
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`else
    logic               unused_gap_len;
    assign unused_gap_len = ^GAP_LEN;
`endif

    assign accept_c = x_valid_q && x_ready;

    // Next-bit selection; advances only on an accepted beat.
    seq_gen_shift #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .IDX_W   (IDX_W)
    ) u_shift (
        .bit_idx    (bit_idx_q),
        .advance    (accept_c),
        .last_c     (last_c),
        .next_idx_c (next_idx_c),
        .next_bit_c (next_bit_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        rep_cnt_d = reps;
                        bit_idx_d = IDX_W'(PAT_W - 1);
                        x_d       = PATTERN[PAT_W-1];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = ST_SEND;
                    end else begin
                        // Empty burst: acknowledge without sending anything.
                        done_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                // Without an accepted beat everything holds (x stable on stall).
                if (accept_c) begin
                    if (!last_c) begin
                        bit_idx_d = next_idx_c;
                        x_d       = next_bit_c;
                    end else if (rep_cnt_q > REP_W'(1)) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        bit_idx_d = next_idx_c;
`ifdef SEQ_GEN_GAP_EN
                        if (GAP_LEN == 0) begin
                            x_d = next_bit_c;
                        end else begin
                            x_d       = 1'b0;
                            x_valid_d = 1'b0;
                            gap_cnt_d = GAP_W'(GAP_LEN - 1);
                            state_d   = ST_GAP;
                        end
`else
                        x_d = next_bit_c;
`endif
                    end else begin
                        x_d       = 1'b0;
                        x_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_FIN;
                    end
                end
            end

            ST_GAP: begin
`ifdef SEQ_GEN_GAP_EN
                // Idle cycles are counted regardless of x_ready.
                if (gap_cnt_q == '0) begin
                    x_d       = PATTERN[PAT_W-1];
                    x_valid_d = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            rep_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            rep_cnt_q <= rep_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SEQ_GEN_GAP_EN
    // Inter-repetition idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen: scoreboard bench for seq_gen. Each burst request pushes the
// expected bit stream (pattern repeated reps times) and a done marker into
// a queue; an independent monitor pops and compares on every accepted beat
// and every done pulse, and checks busy, stall stability and done timing.
// ---------------------------------------------------------------------------
module tb_seq_gen;

    localparam int PW   = 6;
`ifdef SEQ_GEN_GAP_EN
    localparam int GAPC = 2;
`else
    localparam int GAPC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] reps = 4'd0;
    logic       x_ready = 1'b1;
    logic       x, x_valid, busy, done;

    seq_gen #(
        .PAT_W   (6),
        .PATTERN (6'b101010),
        .REP_W   (4),
        .GAP_LEN (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .reps    (reps),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic is_done;
        logic b;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] ref_pat = 6'b101010;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         t_start  = 0;
    int         t_done   = -1;
    int         cur_reps = 0;
    int         ready_mode = 0;
    bit         pend_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic       prev_x = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: 0 = always ready, 1 = random, 2 = fixed 1001101 pattern.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       x_ready = ($urandom_range(0, 99) < 60);
                2: begin
                    x_ready = (k % 7 == 0) || (k % 7 == 3) || (k % 7 == 4) || (k % 7 == 6);
                    k++;
                end
                default: x_ready = 1'b1;
            endcase
        end
    end

    // Monitor: samples mid-cycle, i.e. the values the next rising edge sees.
    always @(negedge clk) begin
        bit front_bit;
        bit front_done;
        if (!rst_n) begin
            prev_stall = 1'b0;
            pend_done  = 1'b0;
        end else begin
            front_bit  = (exp_q.size() > 0) && !exp_q[0].is_done;
            front_done = (exp_q.size() > 0) && exp_q[0].is_done;
            if (pend_done) begin
                chk("done_after_last_bit", 32'(done), 32'd1);
                pend_done = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(x_valid), 32'd1);
                chk("stall_x_hold", 32'(x), 32'(prev_x));
            end
            chk("busy", 32'(busy), 32'(front_bit));
            if (done) begin
                chk("done_expected", 32'(front_done), 32'd1);
                if (front_done) begin
                    void'(exp_q.pop_front());
                    t_done = cyc;
                end
            end
            if (x_valid) begin
                chk("valid_expected", 32'(front_bit), 32'd1);
                if (x_ready && front_bit) begin
                    chk("bit_value", 32'(x), 32'(exp_q[0].b));
                    void'(exp_q.pop_front());
                    if (exp_q.size() > 0 && exp_q[0].is_done) pend_done = 1'b1;
                end
            end
            prev_stall = x_valid && !x_ready;
            prev_x     = x;
        end
    end

    // Request a burst and push its expected response once start is sampled.
    task automatic issue(input int r);
        @(posedge clk);
        #1;
        start = 1'b1;
        reps  = 4'(r);
        @(posedge clk);
        for (int rr = 0; rr < r; rr++) begin
            for (int i = PW - 1; i >= 0; i--) begin
                exp_q.push_back('{is_done: 1'b0, b: ref_pat[i]});
            end
        end
        exp_q.push_back('{is_done: 1'b1, b: 1'b0});
        cur_reps = r;
        t_done   = -1;
        #1;
        start   = 1'b0;
        t_start = cyc;
    endtask

    // Wait (bounded) until the scoreboard drains; check latency when ready=1.
    task automatic wait_done();
        int t;
        int exp_lat;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("burst_complete", 32'(exp_q.size()), 32'd0);
        if (ready_mode == 0) begin
            exp_lat = (cur_reps == 0) ? 0 : cur_reps * PW + (cur_reps - 1) * GAPC;
            chk("done_latency", 32'(t_done - t_start), 32'(exp_lat));
        end
        exp_q.delete();
    endtask

    task automatic run_burst(input int r);
        issue(r);
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x_valid", 32'(x_valid), 32'd0);
        chk("reset_x", 32'(x), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        #2;
        rst_n = 1'b1;

        ready_mode = 0;
        run_burst(1);
        run_burst(3);

        ready_mode = 2;
        run_burst(2);

        ready_mode = 0;
        run_burst(0);

        // A start while sending must be ignored.
        ready_mode = 1;
        issue(2);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        reps  = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        ready_mode = 0;
        run_burst(15);

        // Asynchronous reset after the third accepted bit.
        issue(3);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_x_valid", 32'(x_valid), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_x", 32'(x), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("midreset_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_burst(1);

        for (int n = 0; n < 25; n++) begin
            ready_mode = int'($urandom_range(0, 1));
            run_burst(int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
